// File: rtl/bht_jump_ctrl.sv
// Branch-history-table predictor and jump controller for the IF/ID hand-off:
// predicts IF branches, resolves them in ID, and redirects fetch on a miss.
module bht_jump_ctrl #(
  parameter logic [31:0] MAX_INSADDR = 32'hffff_fff8,
  parameter int          IDX_W       = 4,
  parameter int          CNT_W       = 2,
  parameter int          CNT_INIT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] PC,
  input  logic [31:0] INS,
  input  logic [31:0] rsv,
  input  logic [31:0] rtv,
  output logic [31:0] NPC,
  output logic        clr,
  output logic        pred_taken,
  output logic        halt,
  output logic [15:0] br_cnt,
  output logic [15:0] miss_cnt
);

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;
  localparam int         ENTRIES    = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);

  logic [CNT_W-1:0] cnt [ENTRIES];

  logic [5:0]       if_op;
  logic             if_br, if_jmp, if_jr;
  logic [IDX_W-1:0] if_idx;
  logic [CNT_W-1:0] if_cnt;
  logic [31:0]      if_fallthru, if_target, if_jtarget;

  logic             id_br, id_jr, id_rt0, id_pred, id_taken, mispredict, correct;
  logic [5:0]       id_op;
  logic [IDX_W-1:0] id_idx;
  logic [31:0]      id_target, id_fallthru;

  assign if_op = INS[31:26];

  always_comb begin
    if_br  = 1'b0;
    if_jmp = 1'b0;
    if_jr  = 1'b0;
    case (if_op)
      OP_BEQ, OP_BNE:   if_br  = 1'b1;
      OP_BLEZ, OP_BGTZ: if_br  = (INS[20:16] == 5'd0);
      OP_REGIMM:        if_br  = (INS[20:17] == 4'd0);
      OP_J, OP_JAL:     if_jmp = 1'b1;
      OP_SPECIAL:       if_jr  = (INS[5:0] == 6'd8 && INS[15:11] == 5'd0) ||
                                 (INS[5:0] == 6'd9 && INS[20:16] == 5'd0 && INS[10:6] == 5'd0);
      default: ;
    endcase
  end

  // The IF stage reads the counter before any same-cycle ID update lands.
  assign if_idx      = PC[IDX_W+1:2];
  assign if_cnt      = cnt[if_idx];
  assign pred_taken  = if_br & if_cnt[CNT_W-1];
  assign if_fallthru = PC + 32'd4;
  assign if_target   = if_fallthru + {{14{INS[15]}}, INS[15:0], 2'b00};
  assign if_jtarget  = {PC[31:28], INS[25:0], 2'b00};
  assign halt        = (PC >= MAX_INSADDR);

  always_comb begin
    id_taken = 1'b0;
    case (id_op)
      OP_BEQ:    id_taken = (rsv == rtv);
      OP_BNE:    id_taken = (rsv != rtv);
      OP_BLEZ:   id_taken = ($signed(rsv) <= 0);
      OP_BGTZ:   id_taken = ($signed(rsv) > 0);
      OP_REGIMM: id_taken = id_rt0 ? ($signed(rsv) >= 0) : ($signed(rsv) < 0);
      default: ;
    endcase
  end

  assign mispredict = id_br & (id_taken != id_pred);
  assign correct    = ~stall & (id_jr | mispredict);
  assign clr        = correct;

  always_comb begin
    NPC = if_fallthru;
    if (stall)
      NPC = PC;
    else if (id_jr)
      NPC = rsv;
    else if (mispredict)
      NPC = id_taken ? id_target : id_fallthru;
    else if (halt)
      NPC = PC;
    else if (pred_taken)
      NPC = if_target;
    else if (if_jmp)
      NPC = if_jtarget;
  end

  // A flushed IF slot enters ID as a bubble so it can never trigger a correction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_br       <= 1'b0;
      id_jr       <= 1'b0;
      id_op       <= '0;
      id_rt0      <= 1'b0;
      id_idx      <= '0;
      id_pred     <= 1'b0;
      id_target   <= '0;
      id_fallthru <= '0;
    end else if (!stall) begin
      id_br       <= if_br & ~correct;
      id_jr       <= if_jr & ~correct;
      id_op       <= if_op;
      id_rt0      <= INS[16];
      id_idx      <= if_idx;
      id_pred     <= pred_taken;
      id_target   <= if_target;
      id_fallthru <= if_fallthru;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt[i] <= CNT_RST;
    end else if (!stall && id_br) begin
      if (id_taken)
        cnt[id_idx] <= (cnt[id_idx] == CNT_MAX) ? CNT_MAX : cnt[id_idx] + 1'b1;
      else
        cnt[id_idx] <= (cnt[id_idx] == '0) ? '0 : cnt[id_idx] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (!stall && id_br) begin
      if (br_cnt != 16'hffff)
        br_cnt <= br_cnt + 16'd1;
      if (mispredict && miss_cnt != 16'hffff)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bht_jump_ctrl.sv
// Directed bench for bht_jump_ctrl: a table-level model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_bht_jump_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] BEQ   = 32'h1022_0004;
  localparam logic [31:0] BNE   = 32'h1422_0002;
  localparam logic [31:0] BGEZ  = 32'h0481_0008;
  localparam logic [31:0] JR    = 32'h0060_0008;

  logic        clk = 1'b0, rst = 1'b0, stall = 1'b0;
  logic [31:0] PC = 32'h10, INS = NOP, rsv = '0, rtv = '0;
  logic [31:0] NPC;
  logic        clr, pred_taken, halt;
  logic [15:0] br_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  int          mctr [16];
  int          mbr, mmiss;
  bit          r_br, r_jr, r_pred;
  int          r_kind, r_idx;
  logic [31:0] r_tgt, r_ft;

  bit          pend;
  int          n_ctr, n_idx, n_br, n_miss, n_kind, n_ridx;
  bit          n_upd, n_rbr, n_rjr, n_rpred;
  logic [31:0] n_tgt, n_ft;

  bht_jump_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .PC(PC), .INS(INS), .rsv(rsv), .rtv(rtv),
    .NPC(NPC), .clr(clr), .pred_taken(pred_taken), .halt(halt),
    .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Kinds: 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 J/JAL, 8 JR/JALR.
  function automatic int kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'd4:       return 1;
      6'd5:       return 2;
      6'd6:       return (ins[20:16] == 5'd0) ? 3 : 0;
      6'd7:       return (ins[20:16] == 5'd0) ? 4 : 0;
      6'd1:       return (ins[20:16] == 5'd0) ? 5 : (ins[20:16] == 5'd1) ? 6 : 0;
      6'd2, 6'd3: return 7;
      6'd0:       return ((ins[5:0] == 6'd8 && ins[15:11] == 5'd0) ||
                          (ins[5:0] == 6'd9 && ins[20:16] == 5'd0 && ins[10:6] == 5'd0)) ? 8 : 0;
      default:    return 0;
    endcase
  endfunction

  function automatic bit resolve(input int k, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (k)
      1: return a == b;
      2: return a != b;
      3: return sa <= 0;
      4: return sa > 0;
      5: return sa < 0;
      6: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mctr[i] = 1;
    mbr = 0; mmiss = 0;
    r_br = 0; r_jr = 0; r_pred = 0; r_kind = 0; r_idx = 0;
    r_tgt = '0; r_ft = '0;
    pend = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit st, input logic [31:0] pc, input logic [31:0] ins,
                               input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    stall = st; PC = pc; INS = ins; rsv = rs; rtv = rt;
    #1;
  endtask

  always @(negedge rst) model_reset();

  // Per-cycle model check; the next model state is committed on the following rising edge.
  always @(negedge clk) begin
    int          k, idx;
    bit          isbr, epred, taken, mis, corr;
    logic [31:0] tgt, ft, enpc;
    if (rst) begin
      k     = kind_of(INS);
      idx   = int'(PC[5:2]);
      isbr  = (k >= 1 && k <= 6);
      epred = isbr && (mctr[idx] >= 2);
      ft    = PC + 32'd4;
      tgt   = ft + {{14{INS[15]}}, INS[15:0], 2'b00};
      taken = resolve(r_kind, rsv, rtv);
      mis   = r_br && (taken != r_pred);
      corr  = !stall && (r_jr || mis);
      if (stall)                  enpc = PC;
      else if (r_jr)              enpc = rsv;
      else if (mis)               enpc = taken ? r_tgt : r_ft;
      else if (PC >= 32'hffff_fff8) enpc = PC;
      else if (epred)             enpc = tgt;
      else if (k == 7)            enpc = {PC[31:28], INS[25:0], 2'b00};
      else                        enpc = ft;
      checkOutput("model_npc", NPC, enpc);
      checkOutput("model_clr", {31'd0, clr}, {31'd0, corr});
      checkOutput("model_pred", {31'd0, pred_taken}, {31'd0, epred});
      checkOutput("model_halt", {31'd0, halt}, {31'd0, PC >= 32'hffff_fff8});
      checkOutput("model_br_cnt", {16'd0, br_cnt}, mbr);
      checkOutput("model_miss_cnt", {16'd0, miss_cnt}, mmiss);
      n_upd   = !stall && r_br;
      n_idx   = r_idx;
      n_ctr   = taken ? ((mctr[r_idx] < 3) ? mctr[r_idx] + 1 : 3)
                      : ((mctr[r_idx] > 0) ? mctr[r_idx] - 1 : 0);
      n_br    = (n_upd && mbr < 65535) ? mbr + 1 : mbr;
      n_miss  = (n_upd && mis && mmiss < 65535) ? mmiss + 1 : mmiss;
      n_rbr   = isbr && !corr;
      n_rjr   = (k == 8) && !corr;
      n_kind  = k;
      n_ridx  = idx;
      n_rpred = epred;
      n_tgt   = tgt;
      n_ft    = ft;
      pend    = 1;
    end
  end

  always @(posedge clk) begin
    if (rst && pend) begin
      if (n_upd) mctr[n_idx] = n_ctr;
      mbr = n_br;
      mmiss = n_miss;
      if (!stall) begin
        r_br = n_rbr; r_jr = n_rjr; r_kind = n_kind; r_idx = n_ridx;
        r_pred = n_rpred; r_tgt = n_tgt; r_ft = n_ft;
      end
    end
    pend = 0;
  end

  initial begin
    model_reset();
    #3;
    checkOutput("reset_npc", NPC, 32'h14);
    checkOutput("reset_clr", {31'd0, clr}, 32'd0);
    checkOutput("reset_br_cnt", {16'd0, br_cnt}, 32'd0);
    checkOutput("reset_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    #20 rst = 1'b1;

    // First BEQ mispredicts (weakly not-taken start), then trains taken.
    applyStimulus(0, 32'h40, BEQ, 0, 0);
    checkOutput("beq1_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("beq1_npc", NPC, 32'h44);
    applyStimulus(0, 32'h44, NOP, 5, 5);
    checkOutput("beq1_clr", {31'd0, clr}, 32'd1);
    checkOutput("beq1_fix_npc", NPC, 32'h54);
    applyStimulus(0, 32'h54, NOP, 0, 0);
    checkOutput("beq1_miss_cnt", {16'd0, miss_cnt}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h40, BEQ, 0, 0);
      checkOutput("beq_rep_pred", {31'd0, pred_taken}, 32'd1);
      checkOutput("beq_rep_npc", NPC, 32'h54);
      applyStimulus(0, 32'h54, NOP, 7, 7);
      checkOutput("beq_rep_clr", {31'd0, clr}, 32'd0);
      checkOutput("beq_rep_npc2", NPC, 32'h58);
    end
    applyStimulus(0, 32'h58, NOP, 0, 0);
    checkOutput("beq_rep_miss", {16'd0, miss_cnt}, 32'd1);
    checkOutput("beq_rep_br", {16'd0, br_cnt}, 32'd4);

    // JR redirects to rsv and squashes the branch fetched behind it.
    applyStimulus(0, 32'h80, JR, 0, 0);
    checkOutput("jr_if_npc", NPC, 32'h84);
    applyStimulus(0, 32'h84, BEQ, 32'h100, 0);
    checkOutput("jr_clr", {31'd0, clr}, 32'd1);
    checkOutput("jr_npc", NPC, 32'h100);
    applyStimulus(0, 32'h100, NOP, 9, 9);
    checkOutput("jr_squash_clr", {31'd0, clr}, 32'd0);
    checkOutput("jr_squash_npc", NPC, 32'h104);

    // BGEZ on a negative value against a saturated counter, twice.
    applyStimulus(0, 32'h40, BGEZ, 0, 0);
    checkOutput("bgez_pred", {31'd0, pred_taken}, 32'd1);
    checkOutput("bgez_npc", NPC, 32'h64);
    applyStimulus(0, 32'h64, NOP, 32'hffff_fffc, 0);
    checkOutput("bgez_clr", {31'd0, clr}, 32'd1);
    checkOutput("bgez_fix_npc", NPC, 32'h44);
    applyStimulus(0, 32'h40, BGEZ, 0, 0);
    checkOutput("bgez2_pred", {31'd0, pred_taken}, 32'd1);
    applyStimulus(0, 32'h64, NOP, 32'hffff_fffc, 0);
    checkOutput("bgez2_clr", {31'd0, clr}, 32'd1);
    applyStimulus(0, 32'h40, BEQ, 0, 0);
    checkOutput("ctr_down_pred", {31'd0, pred_taken}, 32'd0);
    applyStimulus(0, 32'h44, NOP, 1, 2);
    checkOutput("ctr_down_clr", {31'd0, clr}, 32'd0);

    // A stalled ID branch must wait, then resolve on the first free cycle.
    applyStimulus(0, 32'h48, BNE, 0, 0);
    checkOutput("bne_npc", NPC, 32'h4c);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h4c, NOP, 1, 2);
      checkOutput("stall_clr", {31'd0, clr}, 32'd0);
      checkOutput("stall_npc", NPC, 32'h4c);
    end
    applyStimulus(0, 32'h4c, NOP, 1, 2);
    checkOutput("unstall_clr", {31'd0, clr}, 32'd1);
    checkOutput("unstall_npc", NPC, 32'h54);
    applyStimulus(0, 32'h54, NOP, 0, 0);
    checkOutput("stats_br", {16'd0, br_cnt}, 32'd8);
    checkOutput("stats_miss", {16'd0, miss_cnt}, 32'd4);

    applyStimulus(0, 32'hffff_fff4, NOP, 0, 0);
    checkOutput("prehalt_halt", {31'd0, halt}, 32'd0);
    checkOutput("prehalt_npc", NPC, 32'hffff_fff8);
    applyStimulus(0, 32'hffff_fff8, NOP, 0, 0);
    checkOutput("halt_halt", {31'd0, halt}, 32'd1);
    checkOutput("halt_npc", NPC, 32'hffff_fff8);

    // Reset lands mid-cycle while a mispredict is pending.
    applyStimulus(0, 32'h48, BNE, 0, 0);
    checkOutput("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
    applyStimulus(0, 32'h4c, NOP, 3, 3);
    checkOutput("pre_rst_clr", {31'd0, clr}, 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_clr", {31'd0, clr}, 32'd0);
    checkOutput("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
    checkOutput("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
    checkOutput("rst_npc", NPC, 32'h50);
    rst = 1'b1;
    applyStimulus(0, 32'h48, BNE, 0, 0);
    checkOutput("post_rst_pred", {31'd0, pred_taken}, 32'd0);
    checkOutput("post_rst_npc", NPC, 32'h4c);
    applyStimulus(0, 32'h4c, NOP, 0, 0);
    checkOutput("post_rst_clr", {31'd0, clr}, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
